// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Load hits return data the same cycle; misses and stores stall until the memory ack.
module dcache_ctrl #(
    parameter int LINES = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    output logic [31:0] cpu_rdata_o,
    output logic        cpu_stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);
    localparam int IDX  = $clog2(LINES);
    localparam int TAGW = 30 - IDX;

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t state_q, state_d;

    logic [LINES-1:0] valid_q;
    logic [TAGW-1:0]  tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    logic [IDX-1:0]  cpu_idx, fill_idx;
    logic [TAGW-1:0] cpu_tag, fill_tag;
    logic            hit;
    logic            unused_addr_lsbs;

    assign cpu_idx  = cpu_addr_i[IDX+1:2];
    assign cpu_tag  = cpu_addr_i[31:IDX+2];
    // The fill target comes from the held request address, not the live CPU bus.
    assign fill_idx = mem_addr_o[IDX+1:2];
    assign fill_tag = mem_addr_o[31:IDX+2];
    assign hit      = cpu_req_i & valid_q[cpu_idx] & (tag_q[cpu_idx] == cpu_tag);
    assign unused_addr_lsbs = ^cpu_addr_i[1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        cpu_stall_o = 1'b0;
        cpu_rdata_o = 32'h0;
        case (state_q)
            IDLE: begin
                if (cpu_req_i) begin
                    if (cpu_we_i) begin
                        cpu_stall_o = 1'b1;
                        state_d     = WRITE;
                    end else if (hit) begin
                        cpu_rdata_o = data_q[cpu_idx];
                    end else begin
                        cpu_stall_o = 1'b1;
                        state_d     = READ;
                    end
                end
            end
            READ: begin
                if (mem_ack_i) begin
                    cpu_rdata_o = mem_rdata_i;
                    state_d     = IDLE;
                end else begin
                    cpu_stall_o = 1'b1;
                end
            end
            WRITE: begin
                if (mem_ack_i) state_d     = IDLE;
                else           cpu_stall_o = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= 32'h0;
            mem_wdata_o <= 32'h0;
        end else begin
            mem_req_o <= (state_d != IDLE);
            if (state_q == IDLE && cpu_req_i && (cpu_we_i || !hit)) begin
                mem_addr_o  <= {cpu_addr_i[31:2], 2'b00};
                mem_we_o    <= cpu_we_i;
                mem_wdata_o <= cpu_we_i ? cpu_wdata_i : mem_wdata_o;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            valid_q <= '0;
        else if (state_q == READ && mem_ack_i)
            valid_q[fill_idx] <= 1'b1;
    end

    // Tag and data carry no reset; valid bits alone qualify them.
    always_ff @(posedge clk_i) begin
        if (state_q == READ && mem_ack_i) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= mem_rdata_i;
        end else if (state_q == IDLE && cpu_we_i && hit) begin
            data_q[cpu_idx] <= cpu_wdata_i;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: inputs change on the falling edge and
// outputs are checked 1ns later, away from the rising edge.
module tb_dcache_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dcache_ctrl #(.LINES(16)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
        .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(negedge clk);
    endtask

    task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic ack, input logic [31:0] rdata);
        cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        mem_ack = ack; mem_rdata = rdata;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        next_cyc(); next_cyc();
        #1;
        chk("rst_mem_req",   {31'h0, mem_req},   32'h0);
        chk("rst_mem_we",    {31'h0, mem_we},    32'h0);
        chk("rst_mem_addr",  mem_addr,           32'h0);
        chk("rst_mem_wdata", mem_wdata,          32'h0);
        chk("rst_rdata",     cpu_rdata,          32'h0);
        chk("rst_stall",     {31'h0, cpu_stall}, 32'h0);
        next_cyc();
        rst_n = 1'b1;
        next_cyc();

        // Cold read miss of 0x40, ack two cycles after mem_req rises.
        drive(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0);
        chk("cold_stall_c1", {31'h0, cpu_stall}, 32'h1);
        chk("cold_req_c1",   {31'h0, mem_req},   32'h0);
        next_cyc(); #1;
        chk("cold_stall_c2", {31'h0, cpu_stall}, 32'h1);
        chk("cold_req_c2",   {31'h0, mem_req},   32'h1);
        chk("cold_addr",     mem_addr,           32'h40);
        chk("cold_we",       {31'h0, mem_we},    32'h0);
        next_cyc(); #1;
        chk("cold_stall_c3", {31'h0, cpu_stall}, 32'h1);
        next_cyc();
        drive(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 32'hDEADBEEF);
        chk("cold_ack_stall", {31'h0, cpu_stall}, 32'h0);
        chk("cold_ack_rdata", cpu_rdata,          32'hDEADBEEF);

        // Read hit on the same address right after the fill.
        next_cyc();
        drive(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0);
        chk("hit_stall",   {31'h0, cpu_stall}, 32'h0);
        chk("hit_rdata",   cpu_rdata,          32'hDEADBEEF);
        chk("hit_mem_req", {31'h0, mem_req},   32'h0);
        next_cyc(); #1;
        chk("hit_mem_req_after", {31'h0, mem_req}, 32'h0);

        // Conflict: 0x80 shares index 0, ack immediately (K=0).
        drive(1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 32'h0);
        chk("conf_stall", {31'h0, cpu_stall}, 32'h1);
        next_cyc();
        drive(1'b1, 1'b0, 32'h80, 32'h0, 1'b1, 32'h11111111);
        chk("conf_addr",      mem_addr,           32'h80);
        chk("conf_ack_stall", {31'h0, cpu_stall}, 32'h0);
        chk("conf_ack_rdata", cpu_rdata,          32'h11111111);
        next_cyc();
        drive(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0);
        chk("evict_miss_stall", {31'h0, cpu_stall}, 32'h1);
        next_cyc();
        drive(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 32'hDEADBEEF);
        chk("evict_req",  {31'h0, mem_req}, 32'h1);
        chk("evict_addr", mem_addr,         32'h40);
        chk("evict_we",   {31'h0, mem_we},  32'h0);

        // Store hit: write-through, line updated.
        next_cyc();
        drive(1'b1, 1'b1, 32'h40, 32'h12345678, 1'b0, 32'h0);
        chk("sthit_stall", {31'h0, cpu_stall}, 32'h1);
        next_cyc();
        drive(1'b1, 1'b1, 32'h40, 32'h12345678, 1'b1, 32'h0);
        chk("sthit_req",   {31'h0, mem_req}, 32'h1);
        chk("sthit_we",    {31'h0, mem_we},  32'h1);
        chk("sthit_addr",  mem_addr,         32'h40);
        chk("sthit_wdata", mem_wdata,        32'h12345678);
        chk("sthit_ack_stall", {31'h0, cpu_stall}, 32'h0);
        chk("sthit_ack_rdata", cpu_rdata,          32'h0);
        next_cyc();
        drive(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0);
        chk("sthit_load_stall", {31'h0, cpu_stall}, 32'h0);
        chk("sthit_load_rdata", cpu_rdata,          32'h12345678);
        chk("sthit_req_drop",   {31'h0, mem_req},   32'h0);

        // Store miss to 0x100 (index 0, other tag): no allocation.
        next_cyc();
        drive(1'b1, 1'b1, 32'h100, 32'hCAFEF00D, 1'b0, 32'h0);
        chk("stmiss_stall", {31'h0, cpu_stall}, 32'h1);
        next_cyc();
        drive(1'b1, 1'b1, 32'h100, 32'hCAFEF00D, 1'b1, 32'h0);
        chk("stmiss_we",    {31'h0, mem_we}, 32'h1);
        chk("stmiss_addr",  mem_addr,        32'h100);
        chk("stmiss_wdata", mem_wdata,       32'hCAFEF00D);
        next_cyc();
        drive(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0);
        chk("stmiss_keep_stall", {31'h0, cpu_stall}, 32'h0);
        chk("stmiss_keep_rdata", cpu_rdata,          32'h12345678);
        next_cyc();
        drive(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0);
        chk("stmiss_load_stall", {31'h0, cpu_stall}, 32'h1);
        next_cyc(); #1;
        chk("stmiss_load_req",  {31'h0, mem_req}, 32'h1);
        chk("stmiss_load_we",   {31'h0, mem_we},  32'h0);
        chk("stmiss_load_addr", mem_addr,         32'h100);

        // Reset while in READ with no ack: abandon and drop everything at once.
        next_cyc();
        cpu_req = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("mid_rst_req",   {31'h0, mem_req},   32'h0);
        chk("mid_rst_we",    {31'h0, mem_we},    32'h0);
        chk("mid_rst_addr",  mem_addr,           32'h0);
        chk("mid_rst_wdata", mem_wdata,          32'h0);
        chk("mid_rst_stall", {31'h0, cpu_stall}, 32'h0);
        chk("mid_rst_rdata", cpu_rdata,          32'h0);
        next_cyc();
        rst_n = 1'b1;
        next_cyc();
        drive(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0);
        chk("post_rst_miss_stall", {31'h0, cpu_stall}, 32'h1);
        next_cyc();
        drive(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 32'hA5A5A5A5);
        chk("post_rst_req",   {31'h0, mem_req}, 32'h1);
        chk("post_rst_addr",  mem_addr,         32'h40);
        chk("post_rst_rdata", cpu_rdata,        32'hA5A5A5A5);
        next_cyc();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        chk("idle_ack_stall", {31'h0, cpu_stall}, 32'h0);
        next_cyc(); #1;
        chk("idle_ack_ignored", {31'h0, mem_req}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
